uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmit path of the APB UART core among up to four on-chip byte producers. A grant is held for a whole packet, closed by `req_last`, so bytes from different producers never interleave on TX. The block sits between the producers and the UART write port (`wr_uart`/`w_data`), and honours the transmit FIFO back-pressure (`tx_full`).

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX write port among NREQ byte producers, one whole packet per grant.
// Define UART_ARB_TIMEOUT_EN to build the idle-owner timeout (revokes a grant after TIMEOUT silent cycles).
module uart_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int BITWIDTH = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                     PCLK,
  input  logic                     PRESETN,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*BITWIDTH-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     tx_full,
  output logic                     wr_uart,
  output logic [BITWIDTH-1:0]      w_data,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [NREQ-1:0]     grant_reg, grant_next;
  logic [IW-1:0]       owner_reg, owner_next;
  logic [IW-1:0]       last_idx_reg, last_idx_next;
  logic [IW-1:0]       cand;
  logic                owner_valid;
  logic                owner_last;
  logic                xfer;
  logic                timeout_hit;
  logic [BITWIDTH-1:0] owner_data;
  logic [BITWIDTH-1:0] data_masked [NREQ];

  // grant_reg is one-hot, so masking with it picks the owner's signals without an index mux
  assign owner_valid = |(req_valid & grant_reg);
  assign owner_last  = |(req_last & grant_reg);
  assign xfer        = (state_reg == S_LOCK) && owner_valid && !tx_full;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign data_masked[gi] = req_data[gi*BITWIDTH +: BITWIDTH] & {BITWIDTH{grant_reg[gi]}};
    end
  endgenerate

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      owner_data = owner_data | data_masked[i];
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] idle_cnt_reg, idle_cnt_next;
  logic       timeout_err_reg;

  // Fires on the TIMEOUT-th silent LOCK cycle; tx_full stalls with valid high are not silent
  assign timeout_hit = (state_reg == S_LOCK) && !owner_valid && (idle_cnt_reg == TIMEOUT_LAST);

  always_comb begin
    idle_cnt_next = idle_cnt_reg;
    if (state_reg != S_LOCK || xfer) begin
      idle_cnt_next = '0;
    end else if (!owner_valid) begin
      idle_cnt_next = idle_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      idle_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      idle_cnt_reg    <= idle_cnt_next;
      timeout_err_reg <= timeout_hit;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state_reg    <= S_IDLE;
      grant_reg    <= '0;
      owner_reg    <= '0;
      last_idx_reg <= IW'(NREQ - 1);
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      owner_reg    <= owner_next;
      last_idx_reg <= last_idx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    owner_next    = owner_reg;
    last_idx_next = last_idx_reg;
    cand          = '0;
    case (state_reg)
      S_IDLE: begin
        // Scan farthest-first so the nearest valid requester after last_idx wins
        for (int k = NREQ; k >= 1; k--) begin
          cand = IW'((int'(last_idx_reg) + k) % NREQ);
          if (req_valid[cand]) begin
            state_next       = S_LOCK;
            owner_next       = cand;
            grant_next       = '0;
            grant_next[cand] = 1'b1;
          end
        end
      end
      S_LOCK: begin
        if ((xfer && owner_last) || timeout_hit) begin
          state_next    = S_IDLE;
          grant_next    = '0;
          last_idx_next = owner_reg;
        end
      end
      default: begin
        state_next = S_IDLE;
        grant_next = '0;
      end
    endcase
  end

  // Reset gates the strobe combinationally so an abandoned packet never writes in the reset cycle
  always_comb begin
    wr_uart   = 1'b0;
    req_ready = '0;
    w_data    = '0;
    if (PRESETN && state_reg == S_LOCK) begin
      wr_uart   = owner_valid && !tx_full;
      req_ready = tx_full ? '0 : grant_reg;
      w_data    = owner_data;
    end
  end

  assign grant = grant_reg;
  assign busy  = (state_reg == S_LOCK);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a packet-level owner model.
// The timeout scenario is exercised when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int BW   = 8;
  localparam int TMO  = 4;
  localparam int VW   = NREQ + 1 + 1 + NREQ + BW + 1;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int DROP = 3;
`else
  localparam int DROP = 10;
`endif

  logic                 PCLK = 1'b0;
  logic                 PRESETN = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ*BW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_full = 1'b0;
  logic                 wr_uart;
  logic [BW-1:0]        w_data;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic                 timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: current owner index (-1 = nobody), last served index, silent-cycle count
  int m_owner = -1;
  int m_last  = NREQ - 1;
  int m_idle  = 0;
  bit m_tmo   = 1'b0;

  always #5 PCLK = ~PCLK;

  uart_tx_arbiter #(.NREQ(NREQ), .BITWIDTH(BW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .tx_full(tx_full), .wr_uart(wr_uart),
    .w_data(w_data), .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always @(negedge PCLK) begin
    if (wr_uart) $display("tx: grant=%b byte=%h", grant, w_data);
  end

  function automatic logic [VW-1:0] obs_vec();
    return {grant, busy, wr_uart, req_ready, w_data, timeout_err};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [NREQ-1:0] g   = '0;
    logic [NREQ-1:0] rdy = '0;
    logic            wr  = 1'b0;
    logic [BW-1:0]   d   = '0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      if (PRESETN) begin
        d = req_data[m_owner*BW +: BW];
        if (!tx_full) begin
          rdy = g;
          wr  = req_valid[m_owner];
        end
      end
    end
    return {g, (m_owner >= 0), wr, rdy, d, m_tmo};
  endfunction

  task automatic model_update();
    if (!PRESETN) begin
      m_owner = -1; m_last = NREQ - 1; m_idle = 0; m_tmo = 1'b0;
      return;
    end
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (req_valid[(m_last + k) % NREQ]) begin
          m_owner = (m_last + k) % NREQ;
          m_idle  = 0;
          break;
        end
      end
    end else if (req_valid[m_owner] && !tx_full) begin
      m_idle = 0;
      if (req_last[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (!req_valid[m_owner]) begin
      m_idle++;
`ifdef UART_ARB_TIMEOUT_EN
      if (m_idle == TMO) begin
        m_tmo   = 1'b1;
        m_last  = m_owner;
        m_owner = -1;
      end
`endif
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge PCLK);
    #1;
  endtask

  task automatic reset_dut();
    PRESETN = 1'b0; req_valid = '0; req_last = '0; tx_full = 1'b0;
    tick();
    PRESETN = 1'b1;
  endtask

  task automatic test_reset();
    PRESETN = 1'b0; req_valid = '1; req_last = '0; req_data = '0; tx_full = 1'b0;
    tick(); tick();
    @(negedge PCLK);
    n_checks++;
    if (grant !== '0 || busy !== 1'b0 || wr_uart !== 1'b0 || req_ready !== '0 || timeout_err !== 1'b0)
      $display("FAIL reset_state: got grant=%b busy=%b wr=%b rdy=%b terr=%b want all 0", grant, busy, wr_uart, req_ready, timeout_err);
    else n_pass++;
    tick();
    PRESETN = 1'b1; req_data[7:0] = 8'hA0;
    @(negedge PCLK);
    n_checks++;
    if (grant !== 4'b0000 || obs_vec() !== exp_vec())
      $display("FAIL reset_first_idle: got %h want %h (grant %b)", obs_vec(), exp_vec(), grant);
    else n_pass++;
    tick();
    for (int i = 0; i < 3; i++) begin
      req_data[7:0] = 8'(8'hA0 + i);
      req_last[0]   = (i == 2);
      @(negedge PCLK);
      n_checks++;
      if (grant !== 4'b0001 || wr_uart !== 1'b1 || w_data !== 8'(8'hA0 + i) || obs_vec() !== exp_vec())
        $display("FAIL reset_pkt_byte%0d: got grant=%b wr=%b data=%h want 0001/1/%h", i, grant, wr_uart, w_data, 8'(8'hA0 + i));
      else n_pass++;
      tick();
    end
    req_last = '0;
    @(negedge PCLK);
    n_checks++;
    if (grant !== 4'b0000 || wr_uart !== 1'b0 || obs_vec() !== exp_vec())
      $display("FAIL reset_gap: got grant=%b wr=%b want 0000/0", grant, wr_uart);
    else n_pass++;
    tick();
    @(negedge PCLK);
    n_checks++;
    if (grant !== 4'b0010 || obs_vec() !== exp_vec())
      $display("FAIL reset_next_grant: got %b want 0010", grant);
    else n_pass++;
    req_last = '1;
    tick();
    req_valid = '0; req_last = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] want;
    reset_dut();
    req_valid = 4'b1010; req_last = '1; req_data = 32'h33221100;
    for (int c = 0; c < 8; c++) begin
      want = (c % 2 == 0) ? 4'b0000 : ((c % 4 == 1) ? 4'b0010 : 4'b1000);
      @(negedge PCLK);
      n_checks++;
      if (grant !== want || obs_vec() !== exp_vec())
        $display("FAIL round_robin_c%0d: got grant=%b vec=%h want grant=%b vec=%h", c, grant, obs_vec(), want, exp_vec());
      else n_pass++;
      tick();
    end
    req_valid = '0; req_last = '0;
    tick(); tick();
  endtask

  task automatic test_back_pressure();
    reset_dut();
    req_valid = 4'b0100; req_last = '0; req_data[23:16] = 8'h55;
    tick();
    @(negedge PCLK);
    n_checks++;
    if (grant !== 4'b0100 || wr_uart !== 1'b1 || obs_vec() !== exp_vec())
      $display("FAIL bp_first_byte: got grant=%b wr=%b want 0100/1", grant, wr_uart);
    else n_pass++;
    tick();
    tx_full = 1'b1; req_data[23:16] = 8'h66;
    for (int c = 0; c < 5; c++) begin
      @(negedge PCLK);
      n_checks++;
      if (wr_uart !== 1'b0 || req_ready !== '0 || grant !== 4'b0100 || obs_vec() !== exp_vec())
        $display("FAIL bp_stall_c%0d: got wr=%b rdy=%b grant=%b want 0/0000/0100", c, wr_uart, req_ready, grant);
      else n_pass++;
      tick();
    end
    tx_full = 1'b0; req_last[2] = 1'b1;
    @(negedge PCLK);
    n_checks++;
    if (wr_uart !== 1'b1 || req_ready !== 4'b0100 || w_data !== 8'h66 || obs_vec() !== exp_vec())
      $display("FAIL bp_release: got wr=%b rdy=%b data=%h want 1/0100/66", wr_uart, req_ready, w_data);
    else n_pass++;
    tick();
    req_valid = '0; req_last = '0;
    @(negedge PCLK);
    n_checks++;
    if (grant !== 4'b0000 || obs_vec() !== exp_vec())
      $display("FAIL bp_end: got grant=%b want 0000", grant);
    else n_pass++;
    tick();
  endtask

  task automatic test_no_interleave();
    reset_dut();
    req_valid = 4'b0100; req_last = '0; req_data = 32'h00440011;
    tick();
    tick();
    req_valid = 4'b0001;
    for (int c = 0; c < DROP; c++) begin
      @(negedge PCLK);
      n_checks++;
      if (grant !== 4'b0100 || wr_uart !== 1'b0 || obs_vec() !== exp_vec())
        $display("FAIL noint_hold_c%0d: got grant=%b wr=%b want 0100/0", c, grant, wr_uart);
      else n_pass++;
      tick();
    end
    req_valid = 4'b0101; req_last = 4'b0100; req_data[23:16] = 8'h77;
    @(negedge PCLK);
    n_checks++;
    if (wr_uart !== 1'b1 || w_data !== 8'h77 || obs_vec() !== exp_vec())
      $display("FAIL noint_resume: got wr=%b data=%h want 1/77", wr_uart, w_data);
    else n_pass++;
    tick();
    tick();
    @(negedge PCLK);
    n_checks++;
    if (grant !== 4'b0001 || obs_vec() !== exp_vec())
      $display("FAIL noint_next_owner: got grant=%b want 0001", grant);
    else n_pass++;
    req_valid = '0; req_last = '0;
    tick();
  endtask

  task automatic test_timeout();
    int pulses = 0;
    reset_dut();
    req_valid = 4'b0010; req_last = '0;
    tick();
    tick();
    req_valid = 4'b0001;
`ifdef UART_ARB_TIMEOUT_EN
    for (int c = 0; c < 6; c++) begin
      @(negedge PCLK);
      if (timeout_err === 1'b1) pulses++;
      n_checks++;
      if (grant !== ((c < 4) ? 4'b0010 : (c == 4) ? 4'b0000 : 4'b0001) || timeout_err !== (c == 4) || obs_vec() !== exp_vec())
        $display("FAIL timeout_c%0d: got grant=%b terr=%b vec=%h want vec=%h", c, grant, timeout_err, obs_vec(), exp_vec());
      else n_pass++;
      tick();
    end
    n_checks++;
    if (pulses !== 1) $display("FAIL timeout_pulses: got %0d want 1", pulses);
    else n_pass++;
`else
    for (int c = 0; c < 20; c++) begin
      @(negedge PCLK);
      if (timeout_err === 1'b1) pulses++;
      n_checks++;
      if (grant !== 4'b0010 || obs_vec() !== exp_vec())
        $display("FAIL silent_hold_c%0d: got grant=%b terr=%b want 0010/0", c, grant, timeout_err);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (pulses !== 0) $display("FAIL silent_no_pulse: got %0d want 0", pulses);
    else n_pass++;
`endif
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    reset_dut();
    req_valid = 4'b0001; req_last = '0; req_data[7:0] = 8'hB0;
    tick();
    tick();
    PRESETN = 1'b0;
    @(negedge PCLK);
    n_checks++;
    if (wr_uart !== 1'b0 || req_ready !== '0 || obs_vec() !== exp_vec())
      $display("FAIL rstmid_reset_cycle: got wr=%b rdy=%b want 0/0000", wr_uart, req_ready);
    else n_pass++;
    tick();
    PRESETN = 1'b1; req_valid = '1;
    @(negedge PCLK);
    n_checks++;
    if (grant !== '0 || wr_uart !== 1'b0 || busy !== 1'b0 || obs_vec() !== exp_vec())
      $display("FAIL rstmid_after: got grant=%b wr=%b busy=%b want 0000/0/0", grant, wr_uart, busy);
    else n_pass++;
    tick();
    @(negedge PCLK);
    n_checks++;
    if (grant !== 4'b0001 || obs_vec() !== exp_vec())
      $display("FAIL rstmid_regrant: got grant=%b want 0001", grant);
    else n_pass++;
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    int errs = 0;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      PRESETN = ($urandom_range(0, 99) != 0);
      tx_full = ($urandom_range(0, 3) == 0);
      for (int r = 0; r < NREQ; r++) begin
        req_valid[r] = ($urandom_range(0, 3) != 0);
        req_last[r]  = ($urandom_range(0, 2) == 0);
        req_data[r*BW +: BW] = 8'($urandom);
      end
      @(negedge PCLK);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        errs++;
        if (errs <= 10) $display("FAIL random_c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end else n_pass++;
      tick();
    end
    PRESETN = 1'b1; req_valid = '0; req_last = '0; tx_full = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_no_interleave();
    test_timeout();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
